tas_gain_sequencer: RTL and testbench

TAS_GAIN_SEQUENCER -- requirements
Module: tas_gain_sequencer

---
 rtl/tas_seq_pkg.sv | 29 ++
 rtl/tas_gain_sequencer_phase.sv | 49 ++++
 rtl/tas_gain_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_tas_gain_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tas_seq_pkg.sv
// Shared types and constants for the TAS gain sequencer: FSM state encoding
// and the power-up register init table sent before any gain update.
package tas_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BIT,
      ST_ACK,
      ST_STOP,
      ST_GAP
   } state_t;

   localparam int unsigned INIT_LEN   = 4;
   localparam int unsigned INIT_IDX_W = $clog2(INIT_LEN);

   // {register index, data byte}; sent in order after every reset
   localparam logic [15:0] INIT_TABLE [INIT_LEN] = '{
      16'h0000,
      16'h7F00,
      16'h0312,
      16'h0455
   };

   function automatic logic [15:0] init_entry(input logic [INIT_IDX_W-1:0] idx);
      return INIT_TABLE[idx];
   endfunction

endpackage

// File: rtl/tas_gain_sequencer_phase.sv
// tas_i2c_phase_gen: divides clk_clk into SCL quarter-periods of QDIV cycles.
// tick marks the last cycle of a quarter; quarter counts 0..3 and wraps.
// Counters are held at zero while run is low and cleared by clr.
module tas_i2c_phase_gen #(
   parameter int unsigned QDIV = 125
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic       run,
   input  logic       clr,
   output logic       tick,
   output logic [1:0] quarter
);

   localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    qtr_q, qtr_d;

   assign tick    = run & (cnt_q == CW'(QDIV - 1));
   assign quarter = qtr_q;

   // next cycle / quarter count
   always_comb begin
      cnt_d = cnt_q;
      qtr_d = qtr_q;
      if (!run || clr) begin
         cnt_d = '0;
         qtr_d = '0;
      end else if (tick) begin
         cnt_d = '0;
         qtr_d = qtr_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // counter registers
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         cnt_q <= '0;
         qtr_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         qtr_q <= qtr_d;
      end
   end

endmodule

// File: rtl/tas_gain_sequencer.sv
// tas_gain_sequencer: I2C write-only master for a TAS amplifier. After reset
// it sends the init table, then forwards coalesced AGC gain requests as
// master-volume register writes. Each transaction is
// START, addr, reg, data, STOP, GAP.
// Optional macro TAS_SEQ_ACK_CHECK_EN enables NACK detection, the sticky err
// flag and up to 3 retries per transaction.
module tas_gain_sequencer
   import tas_seq_pkg::*;
#(
   parameter int unsigned QDIV     = 125,
   parameter logic [6:0]  DEV_ADDR = 7'h1B,
   parameter logic [7:0]  VOL_REG  = 8'h07
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic       gain_valid,
   input  logic [7:0] gain_data,
   output logic       gain_ready,
   output logic       init_done,
   output logic       busy,
   output logic       err,
   output logic       tas_scl_export,
   output logic       tas_sda_oe,
   input  logic       tas_sda_in
);

   state_t                state_q, state_d;
   logic [INIT_IDX_W-1:0] init_idx_q, init_idx_d;
   logic                  init_done_q, init_done_d;
   logic                  pend_q, pend_d;
   logic [7:0]            pend_data_q, pend_data_d;
   logic                  src_init_q, src_init_d;
   logic [7:0]            shift_q, shift_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [7:0]            reg_q, reg_d;
   logic [7:0]            data_q, data_d;
   logic                  busy_q, busy_d;
   logic                  scl_q, scl_d;
   logic                  sda_oe_q, sda_oe_d;

   logic                  q_tick;
   logic [1:0]            quarter;
   logic                  accept;
   logic                  go_retry, go_init, go_gain;
   logic                  nack_stop;
   logic                  entry_done;

`ifdef TAS_SEQ_ACK_CHECK_EN
   localparam logic [1:0] MAX_RETRIES = 2'd3;
   logic       nack_q, nack_d;
   logic       err_q, err_d;
   logic       retry_q, retry_d;
   logic [1:0] retry_cnt_q, retry_cnt_d;
   assign err = err_q;
`else
   logic sda_in_unused;
   assign sda_in_unused = tas_sda_in;
   assign err = 1'b0;
`endif

   assign gain_ready     = init_done_q;
   assign init_done      = init_done_q;
   assign busy           = busy_q;
   assign tas_scl_export = scl_q;
   assign tas_sda_oe     = sda_oe_q;
   assign accept         = gain_valid & init_done_q;

   tas_i2c_phase_gen #(
      .QDIV(QDIV)
   ) u_phase (
      .clk_clk    (clk_clk),
      .reset_reset(reset_reset),
      .run        (state_q != ST_IDLE),
      .clr        (state_d != state_q),
      .tick       (q_tick),
      .quarter    (quarter)
   );

   // transaction sequencing, init walk and gain coalescing
   always_comb begin
      state_d     = state_q;
      init_idx_d  = init_idx_q;
      init_done_d = init_done_q;
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      src_init_d  = src_init_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      reg_d       = reg_q;
      data_d      = data_q;
      entry_done  = 1'b0;
      go_init     = ~init_done_q;
      go_gain     = init_done_q & pend_q;
`ifdef TAS_SEQ_ACK_CHECK_EN
      nack_d      = nack_q;
      err_d       = err_q;
      retry_d     = retry_q;
      retry_cnt_d = retry_cnt_q;
      go_retry    = retry_q;
      nack_stop   = nack_q;
`else
      go_retry    = 1'b0;
      nack_stop   = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (go_retry || go_init || go_gain) begin
               state_d    = ST_START;
               shift_d    = {DEV_ADDR, 1'b0};
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
`ifdef TAS_SEQ_ACK_CHECK_EN
               nack_d     = 1'b0;
               retry_d    = 1'b0;
`endif
               // a retry resends the latched reg/data untouched
               if (!go_retry) begin
                  if (go_init) begin
                     {reg_d, data_d} = init_entry(init_idx_q);
                     src_init_d      = 1'b1;
                  end else begin
                     reg_d      = VOL_REG;
                     data_d     = pend_data_q;
                     pend_d     = 1'b0;
                     src_init_d = 1'b0;
                  end
               end
            end
         end
         ST_START: begin
            if (q_tick && quarter == 2'd3) state_d = ST_BIT;
         end
         ST_BIT: begin
            if (q_tick && quarter == 2'd3) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d   = ST_ACK;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shift_d   = {shift_q[6:0], 1'b0};
               end
            end
         end
         ST_ACK: begin
`ifdef TAS_SEQ_ACK_CHECK_EN
            if (q_tick && quarter == 2'd2 && tas_sda_in) begin
               nack_d = 1'b1;
               err_d  = 1'b1;
            end
`endif
            if (q_tick && quarter == 2'd3) begin
               if (nack_stop || byte_cnt_q == 2'd2) begin
                  state_d = ST_STOP;
               end else begin
                  state_d    = ST_BIT;
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  shift_d    = (byte_cnt_q == 2'd0) ? reg_q : data_q;
               end
            end
         end
         ST_STOP: begin
            if (q_tick && quarter == 2'd2) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (q_tick && quarter == 2'd3) begin
               state_d    = ST_IDLE;
               entry_done = 1'b1;
`ifdef TAS_SEQ_ACK_CHECK_EN
               if (nack_q && retry_cnt_q != MAX_RETRIES) begin
                  retry_cnt_d = retry_cnt_q + 2'd1;
                  retry_d     = 1'b1;
                  entry_done  = 1'b0;
               end else begin
                  retry_cnt_d = '0;
               end
`endif
               // a dropped init entry still advances the walk
               if (entry_done && src_init_q) begin
                  if (init_idx_q == INIT_IDX_W'(INIT_LEN - 1)) init_done_d = 1'b1;
                  else init_idx_d = init_idx_q + INIT_IDX_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // acceptance wins over the clear done on IDLE->START in the same cycle
      if (accept) begin
         pend_d      = 1'b1;
         pend_data_d = gain_data;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // bus pin levels for the current state and quarter
   always_comb begin
      scl_d    = 1'b1;
      sda_oe_d = 1'b0;
      case (state_q)
         ST_START: begin
            scl_d    = (quarter < 2'd2);
            sda_oe_d = 1'b1;
         end
         ST_BIT: begin
            scl_d    = (quarter == 2'd1) || (quarter == 2'd2);
            sda_oe_d = ~shift_q[7];
         end
         ST_ACK: begin
            scl_d    = (quarter == 2'd1) || (quarter == 2'd2);
            sda_oe_d = 1'b0;
         end
         ST_STOP: begin
            scl_d    = (quarter != 2'd0);
            sda_oe_d = (quarter != 2'd2);
         end
         default: ;
      endcase
   end

   // state and output registers
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q     <= ST_IDLE;
         init_idx_q  <= '0;
         init_done_q <= 1'b0;
         pend_q      <= 1'b0;
         pend_data_q <= '0;
         src_init_q  <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         reg_q       <= '0;
         data_q      <= '0;
         busy_q      <= 1'b0;
         scl_q       <= 1'b1;
         sda_oe_q    <= 1'b0;
`ifdef TAS_SEQ_ACK_CHECK_EN
         nack_q      <= 1'b0;
         err_q       <= 1'b0;
         retry_q     <= 1'b0;
         retry_cnt_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         init_idx_q  <= init_idx_d;
         init_done_q <= init_done_d;
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
         src_init_q  <= src_init_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         reg_q       <= reg_d;
         data_q      <= data_d;
         busy_q      <= busy_d;
         scl_q       <= scl_d;
         sda_oe_q    <= sda_oe_d;
`ifdef TAS_SEQ_ACK_CHECK_EN
         nack_q      <= nack_d;
         err_q       <= err_d;
         retry_q     <= retry_d;
         retry_cnt_q <= retry_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_tas_gain_sequencer.sv
// Testbench for tas_gain_sequencer: an I2C slave/bus monitor decodes each
// transaction and compares it against a scoreboard of expected writes.
// Honours TAS_SEQ_ACK_CHECK_EN when the design is built with it.
`timescale 1ns/1ps
module tb_tas_gain_sequencer;

   localparam int unsigned QDIV = 4;
   localparam logic [23:0] EXP_INIT [4] = '{24'h360000, 24'h367F00, 24'h360312, 24'h360455};

   logic       clk = 1'b0;
   logic       reset_reset;
   logic       gain_valid;
   logic [7:0] gain_data;
   logic       gain_ready, init_done, busy, err;
   logic       tas_scl_export, tas_sda_oe, tas_sda_in;
   logic       slave_pull = 1'b0;
   logic       sda_line;

   assign sda_line   = ~(tas_sda_oe | slave_pull);
   assign tas_sda_in = sda_line;

   always #5 clk = ~clk;

   tas_gain_sequencer #(
      .QDIV    (QDIV),
      .DEV_ADDR(7'h1B),
      .VOL_REG (8'h07)
   ) dut (
      .clk_clk       (clk),
      .reset_reset   (reset_reset),
      .gain_valid    (gain_valid),
      .gain_data     (gain_data),
      .gain_ready    (gain_ready),
      .init_done     (init_done),
      .busy          (busy),
      .err           (err),
      .tas_scl_export(tas_scl_export),
      .tas_sda_oe    (tas_sda_oe),
      .tas_sda_in    (tas_sda_in)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [23:0] sb_q[$];

   // monitor state, only touched through mon_sample()
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   logic       in_txn = 1'b0;
   int         mon_bit = 0, mon_byte = 0, mon_cyc = 0;
   int         rise1 = 0, scl_period = 0;
   int         n_full = 0, n_short = 0;
   int         nack_used = 0;
   int         nack_target = 0;
   logic       ack_en = 1'b1;
   logic [8:0] sh = '0;
   logic [7:0] rx [3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic mon_sample();
      logic [23:0] exp_t;
      mon_cyc++;
      if (reset_reset) begin
         in_txn     = 1'b0;
         slave_pull = 1'b0;
         mon_bit    = 0;
         mon_byte   = 0;
         nack_used  = 0;
      end else if (prev_scl && tas_scl_export && prev_sda && !sda_line) begin
         in_txn   = 1'b1;
         mon_bit  = 0;
         mon_byte = 0;
      end else if (prev_scl && tas_scl_export && !prev_sda && sda_line) begin
         if (in_txn) begin
            if (mon_byte == 3) begin
               n_full++;
               exp_t = (sb_q.size() > 0) ? sb_q.pop_front() : 24'hFFFFFF;
               check("txn", {8'h00, rx[0], rx[1], rx[2]}, {8'h00, exp_t});
            end else begin
               n_short++;
            end
         end
         in_txn = 1'b0;
      end else if (in_txn && !prev_scl && tas_scl_export) begin
         sh = {sh[7:0], sda_line};
         mon_bit++;
         if (mon_byte == 0 && mon_bit == 1) rise1 = mon_cyc;
         if (mon_byte == 0 && mon_bit == 2) scl_period = mon_cyc - rise1;
         if (mon_bit == 9) begin
            if (mon_byte < 3) rx[mon_byte] = sh[8:1];
            mon_byte++;
            mon_bit = 0;
         end
      end else if (in_txn && prev_scl && !tas_scl_export) begin
         if (mon_bit == 8) begin
            if (mon_byte == 0 && nack_used < nack_target) begin
               nack_used++;
               slave_pull = 1'b0;
            end else begin
               slave_pull = ack_en;
            end
         end else if (mon_bit == 0) begin
            slave_pull = 1'b0;
         end
      end
      prev_scl = tas_scl_export;
      prev_sda = sda_line;
   endtask

   task automatic step();
      @(negedge clk);
      mon_sample();
   endtask

   task automatic drive_gain(input logic [7:0] d);
      gain_valid = 1'b1;
      gain_data  = d;
      step();
      gain_valid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 4000; i++) begin
         if (sb_q.size() == 0 && !busy) break;
         step();
      end
      check(tag, 32'(sb_q.size()), 32'd0);
   endtask

   task automatic wait_init(input string tag);
      for (int i = 0; i < 8000; i++) begin
         if (init_done) break;
         step();
      end
      check(tag, 32'(init_done), 32'd1);
   endtask

   task automatic push_init(input int first);
      for (int i = first; i < 4; i++) sb_q.push_back(EXP_INIT[i]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      reset_reset = 1'b1;
      gain_valid  = 1'b0;
      gain_data   = '0;
      repeat (3) step();
      check("rst_scl", 32'(tas_scl_export), 32'd1);
      check("rst_oe", 32'(tas_sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_ready", 32'(gain_ready), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // init sequence, with a request during init that must be dropped
      push_init(0);
      reset_reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (busy) break;
         step();
      end
      check("ready_during_init", 32'(gain_ready), 32'd0);
      drive_gain(8'hEE);
      wait_init("init_done");
      check("busy_at_init_done", 32'(busy), 32'd0);
      check("ready_after_init", 32'(gain_ready), 32'd1);
      check("init_txn_count", 32'(n_full), 32'd4);
      check("init_sb_empty", 32'(sb_q.size()), 32'd0);

      // single gain update and SCL period
      sb_q.push_back(24'h360730);
      drive_gain(8'h30);
      wait_drain("gain30_drain");
      check("scl_period", 32'(scl_period), 32'(4 * QDIV));

      // coalescing while busy: only the newest request follows
      base = n_full;
      sb_q.push_back(24'h360750);
      drive_gain(8'h50);
      for (int i = 0; i < 100; i++) begin
         if (busy) break;
         step();
      end
      drive_gain(8'h10);
      drive_gain(8'h20);
      sb_q.push_back(24'h360720);
      wait_drain("coalesce_drain");
      repeat (1200) step();
      check("coalesce_count", 32'(n_full - base), 32'd2);
      check("coalesce_idle", 32'(busy), 32'd0);

`ifdef TAS_SEQ_ACK_CHECK_EN
      // address NACKed 4 times: entry 0 dropped after 3 retries
      reset_reset = 1'b1;
      repeat (2) step();
      sb_q.delete();
      push_init(1);
      base        = n_short;
      nack_target = 4;
      reset_reset = 1'b0;
      wait_init("nack_init_done");
      check("nack_attempts", 32'(n_short - base), 32'd4);
      check("nack_err", 32'(err), 32'd1);
      check("nack_sb_empty", 32'(sb_q.size()), 32'd0);
      nack_target = 0;
`else
      // without ACK checking a silent slave changes nothing
      ack_en = 1'b0;
      sb_q.push_back(24'h360744);
      drive_gain(8'h44);
      wait_drain("noack_drain");
      check("noack_err", 32'(err), 32'd0);
      ack_en = 1'b1;
`endif

      // reset in the middle of the data byte
      sb_q.push_back(24'h360777);
      drive_gain(8'h77);
      for (int i = 0; i < 2000; i++) begin
         if (mon_byte == 2 && mon_bit == 3) break;
         step();
      end
      check("reached_data_bit3", 32'(mon_byte * 16 + mon_bit), 32'd35);
      reset_reset = 1'b1;
      step();
      check("midrst_scl", 32'(tas_scl_export), 32'd1);
      check("midrst_oe", 32'(tas_sda_oe), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_init_done", 32'(init_done), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      sb_q.delete();
      push_init(0);
      step();
      reset_reset = 1'b0;
      wait_init("reinit_done");
      check("reinit_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
